// File: rtl/booth_r4_seq_ctrl_if.sv
// Operand/result handshake bundle for the radix-4 Booth multiplier controller.
// master = operand source / result consumer, slave = the multiplier.
interface booth_r4_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_r4_seq_ctrl.sv
// Sequential signed radix-4 Booth multiplier: IDLE -> LOAD (multiples) -> RUN (one digit per clock).
// Optional macro BOOTH_ZERO_SKIP_EN finishes in LOAD when either captured operand is zero.
module booth_r4_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  booth_r4_seq_ctrl_if.slave bus
);
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic logic [AW-1:0] neg2c(input logic [AW-1:0] v);
    return ~v + {{(AW-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_r, state_nxt_s;
  logic [WIDTH-1:0]     m_r, q_r;
  logic [AW-1:0]        a_r;
  logic                 q_m1_r;
  logic [CW-1:0]        cnt_r;
  logic [AW-1:0]        pos_m_r, neg_m_r, pos_2m_r, neg_2m_r;
  logic                 busy_r, done_r;
  logic [2*WIDTH-1:0]   product_r;

  logic [AW-1:0]        m_ext_s, pp_s, sum_s, a_nxt_s;
  logic signed [2*WIDTH+2:0] shift_cat_s, shifted_s;
  logic [WIDTH-1:0]     q_nxt_s;
  logic                 q_m1_nxt_s;
  logic                 last_iter_s, zero_op_s;
  logic                 busy_nxt_s, done_nxt_s;
  logic [2*WIDTH-1:0]   product_nxt_s;

  assign m_ext_s     = {{2{m_r[WIDTH-1]}}, m_r};
  assign last_iter_s = (cnt_r == CNT_LAST);
`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op_s   = (m_r == {WIDTH{1'b0}}) || (q_r == {WIDTH{1'b0}});
`else
  assign zero_op_s   = 1'b0;
`endif

  // Booth digit decode into the selected partial product
  always_comb begin
    pp_s = {AW{1'b0}};
    case ({q_r[1:0], q_m1_r})
      3'b001, 3'b010: pp_s = pos_m_r;
      3'b011:         pp_s = pos_2m_r;
      3'b100:         pp_s = neg_2m_r;
      3'b101, 3'b110: pp_s = neg_m_r;
      default:        pp_s = {AW{1'b0}};
    endcase
  end

  // Accumulate then arithmetic shift {A, Q, q_m1} right by one digit
  assign sum_s       = a_r + pp_s;
  assign shift_cat_s = {sum_s, q_r, q_m1_r};
  assign shifted_s   = shift_cat_s >>> 2;
  assign a_nxt_s     = shifted_s[2*WIDTH+2:WIDTH+1];
  assign q_nxt_s     = shifted_s[WIDTH:1];
  assign q_m1_nxt_s  = shifted_s[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_LOAD;
        else           state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (zero_op_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (last_iter_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered handshake outputs
  always_comb begin
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    done_nxt_s    = 1'b0;
    product_nxt_s = product_r;
    if (state_r == ST_RUN && last_iter_s) begin
      done_nxt_s    = 1'b1;
      product_nxt_s = {a_nxt_s[WIDTH-1:0], q_nxt_s};
    end else if (state_r == ST_LOAD && zero_op_s) begin
      done_nxt_s    = 1'b1;
      product_nxt_s = {(2*WIDTH){1'b0}};
    end else begin
      done_nxt_s    = 1'b0;
      product_nxt_s = product_r;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      product_r <= product_nxt_s;
    end
  end

  // Operand capture, multiple precompute and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r      <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      a_r      <= {AW{1'b0}};
      q_m1_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      pos_m_r  <= {AW{1'b0}};
      neg_m_r  <= {AW{1'b0}};
      pos_2m_r <= {AW{1'b0}};
      neg_2m_r <= {AW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            m_r    <= bus.multiplicand;
            q_r    <= bus.multiplier;
            a_r    <= {AW{1'b0}};
            q_m1_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
          end
        end
        ST_LOAD: begin
          pos_m_r  <= m_ext_s;
          neg_m_r  <= neg2c(m_ext_s);
          pos_2m_r <= {m_ext_s[AW-2:0], 1'b0};
          neg_2m_r <= neg2c({m_ext_s[AW-2:0], 1'b0});
        end
        ST_RUN: begin
          a_r    <= a_nxt_s;
          q_r    <= q_nxt_s;
          q_m1_r <= q_m1_nxt_s;
          cnt_r  <= cnt_r + CNT_ONE;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Scoreboard bench for booth_r4_seq_ctrl: driver pushes expected products and done edges,
// a monitor pops and compares whenever done is seen.
module tb_booth_r4_seq_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   ecnt;
  int   total;
  int   bad;
  int   cur_e;
  int   cur_due;
  logic [2*W-1:0] exp_prod;
  exp_t sb[$];

  booth_r4_seq_ctrl_if #(.WIDTH(W)) bus ();

  booth_r4_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    int a;
    int b;
    a = $signed(m);
    b = $signed(q);
    return 16'(a * b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Drive one start cycle; called at a negedge, returns at the next negedge.
  task automatic drive(input logic [W-1:0] m, input logic [W-1:0] q);
    int e;
    int lat;
    e = ecnt + 1;
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    if (e > cur_due) begin
      lat = W / 2 + 1;
`ifdef BOOTH_ZERO_SKIP_EN
      if (m == 8'h00 || q == 8'h00) lat = 1;
`endif
      sb.push_back('{prod: ref_mul(m, q), due: e + lat});
      cur_e   = e;
      cur_due = e + lat;
    end
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_product", 32'(bus.product), 32'd0);
      sb.delete();
      exp_prod = 16'h0000;
    end else begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_edge", 32'(ecnt), 32'(e.due));
          chk("product", 32'(bus.product), 32'(e.prod));
          exp_prod = e.prod;
        end
      end else if (sb.size() != 0 && sb[0].due < ecnt) begin
        e = sb.pop_front();
        chk("missing_done", 32'(ecnt), 32'(e.due));
      end
      chk("busy", 32'(bus.busy), 32'((ecnt >= cur_e) && (ecnt < cur_due)));
      chk("product_hold", 32'(bus.product), 32'(exp_prod));
    end
  end

  initial begin
    ecnt             = 0;
    total            = 0;
    bad              = 0;
    cur_e            = 0;
    cur_due          = -1;
    exp_prod         = 16'h0000;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = 8'h00;
    bus.multiplier   = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    drive(8'd3, 8'd5);      idle(6);
    drive(8'h80, 8'h80);    idle(6);
    drive(8'h80, 8'h7F);    idle(6);
    drive(8'h7F, 8'hFF);    idle(6);

    // starts while busy, then a start in the done cycle
    drive(8'h11, 8'hE5);
    idle(1);
    drive(8'h7F, 8'h7F);
    drive(8'h80, 8'h01);
    for (int i = 0; i < 20 && ecnt < cur_due; i++) @(negedge clk);
    drive(8'hF0, 8'h0C);
    idle(7);

    // reset in the middle of a multiply
    drive(8'h25, 8'h13);
    idle(2);
    rst_n   = 1'b0;
    cur_e   = 0;
    cur_due = -1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    drive(8'd7, 8'hF7);     idle(6);

    drive(8'h00, 8'h55);    idle(6);
    drive(8'h55, 8'h00);    idle(6);

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] m;
      logic [W-1:0] q;
      m = W'($urandom);
      q = W'($urandom);
      case ($urandom_range(0, 7))
        0: m = 8'h80;
        1: q = 8'h80;
        2: m = 8'h00;
        3: q = 8'h7F;
        default: m = m;
      endcase
      drive(m, q);
      idle($urandom_range(0, 4));
    end

    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
